// File: rtl/alu_result_stage_if.sv
// Bundle of the ALU-side and writeback-side signals around the ALU result stage.
// The slave modport is the stage itself; the master modport drives the ALU side and consumes results.
interface alu_result_stage_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       alu_code;
  logic [WIDTH-1:0] result_in;
  logic             carry_in_flag;
  logic             overflow_in;
  logic             zero_in;
  logic             negative_in;
  logic             flags_write_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             wide;
  logic [3:0]       flags_out;
  logic             carry_to_alu;
  logic             seq_error;

  modport master (
    output in_valid, alu_code, result_in, carry_in_flag, overflow_in,
           zero_in, negative_in, flags_write_en, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, wide, flags_out,
           carry_to_alu, seq_error
  );

  modport slave (
    input  in_valid, alu_code, result_in, carry_in_flag, overflow_in,
           zero_in, negative_in, flags_write_en, out_ready,
    output in_ready, out_valid, result_lo, result_hi, wide, flags_out,
           carry_to_alu, seq_error
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registers ALU results and flags for writeback, pairing the two ALU cycles of
// mod/multiply/divide into one wide result, and owns the architectural flags register.
module alu_result_stage #(
  parameter int          WIDTH         = 16,
  parameter logic [31:0] TWO_STEP_MASK = 32'h0003C300
) (
  input logic            clock,
  input logic            reset,
  alu_result_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t           state_q;
  logic [4:0]       code_q;
  logic [WIDTH-1:0] held_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic             wide_q;
  logic [3:0]       flags_q;
  logic             seq_err_q;

  logic             in_ready;
  logic             two_step;
  logic             pair_done;
  logic             abort;
  logic             start;
  logic [3:0]       flags_d;

  // in_ready depends only on state and out_ready so no path exists from ALU data to outputs.
  always_comb begin
    in_ready  = (state_q == FULL) ? bus.out_ready : 1'b1;
    two_step  = TWO_STEP_MASK[bus.alu_code];
    pair_done = (state_q == HI) && bus.in_valid && (bus.alu_code == code_q);
    abort     = (state_q == HI) && !pair_done;
    start     = bus.in_valid && in_ready && !pair_done;
    flags_d   = {bus.overflow_in, bus.carry_in_flag, bus.negative_in, bus.zero_in};
  end

  // A broken pair (bubble or code change in HI) drops the held word; a live new op
  // in that same cycle falls through to the normal start path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      lo_q      <= '0;
      hi_q      <= '0;
      wide_q    <= 1'b0;
      flags_q   <= 4'b0000;
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= abort;
      if (pair_done) begin
        lo_q    <= held_q;
        hi_q    <= bus.result_in;
        wide_q  <= 1'b1;
        if (bus.flags_write_en) flags_q <= flags_d;
        state_q <= FULL;
      end else if (start) begin
        if (two_step) begin
          held_q  <= bus.result_in;
          code_q  <= bus.alu_code;
          state_q <= HI;
        end else begin
          lo_q    <= bus.result_in;
          hi_q    <= '0;
          wide_q  <= 1'b0;
          if (bus.flags_write_en) flags_q <= flags_d;
          state_q <= FULL;
        end
      end else if (abort || ((state_q == FULL) && bus.out_ready)) begin
        state_q <= IDLE;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = (state_q == FULL);
  assign bus.result_lo    = lo_q;
  assign bus.result_hi    = hi_q;
  assign bus.wide         = wide_q;
  assign bus.flags_out    = flags_q;
  assign bus.carry_to_alu = flags_q[2];
  assign bus.seq_error    = seq_err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: a cycle-by-cycle vector table plus
// hand-written reset-in-HI and reset-in-FULL sequences.
module tb_alu_result_stage;

  logic clock = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  alu_result_stage_if #(.WIDTH(16)) bus ();

  alu_result_stage #(.WIDTH(16), .TWO_STEP_MASK(32'h0003C300)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic        v;
    logic [4:0]  code;
    logic [15:0] res;
    logic [3:0]  fl_in;   // {overflow, carry, negative, zero}
    logic        fwe;
    logic        ordy;
    logic        ir;      // in_ready during the cycle
    logic        ov;      // outputs after the edge
    logic [15:0] lo;
    logic [15:0] hi;
    logic        w;
    logic [3:0]  fl;
    logic        se;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  function automatic vec_t mk(input logic rst, input logic v, input logic [4:0] code,
                              input logic [15:0] res, input logic [3:0] fl_in,
                              input logic fwe, input logic ordy, input logic ir,
                              input logic ov, input logic [15:0] lo, input logic [15:0] hi,
                              input logic w, input logic [3:0] fl, input logic se);
    vec_t r;
    r.rst = rst; r.v = v; r.code = code; r.res = res; r.fl_in = fl_in; r.fwe = fwe;
    r.ordy = ordy; r.ir = ir; r.ov = ov; r.lo = lo; r.hi = hi; r.w = w; r.fl = fl; r.se = se;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [4:0] code,
                       input logic [15:0] res, input logic [3:0] fl_in,
                       input logic fwe, input logic ordy);
    reset              = rst;
    bus.in_valid       = v;
    bus.alu_code       = code;
    bus.result_in      = res;
    bus.overflow_in    = fl_in[3];
    bus.carry_in_flag  = fl_in[2];
    bus.negative_in    = fl_in[1];
    bus.zero_in        = fl_in[0];
    bus.flags_write_en = fwe;
    bus.out_ready      = ordy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vt[0]  = mk(1,0,5'h00,16'h0000,4'b0000,0,1, 1,0,16'h0000,16'h0000,0,4'b0000,0);
    vt[1]  = mk(0,0,5'h00,16'h0000,4'b0000,0,1, 1,0,16'h0000,16'h0000,0,4'b0000,0);
    vt[2]  = mk(0,1,5'h0A,16'h1234,4'b0100,1,1, 1,1,16'h1234,16'h0000,0,4'b0100,0);
    vt[3]  = mk(0,1,5'h0E,16'h5678,4'b0000,1,1, 1,0,16'h0000,16'h0000,0,4'b0100,0);
    vt[4]  = mk(0,1,5'h0E,16'h0001,4'b0000,1,0, 1,1,16'h5678,16'h0001,1,4'b0000,0);
    vt[5]  = mk(0,1,5'h0A,16'hAAAA,4'b1100,1,0, 0,1,16'h5678,16'h0001,1,4'b0000,0);
    vt[6]  = mk(0,1,5'h0A,16'hAAAA,4'b1100,1,0, 0,1,16'h5678,16'h0001,1,4'b0000,0);
    vt[7]  = mk(0,1,5'h0A,16'hAAAA,4'b1100,1,0, 0,1,16'h5678,16'h0001,1,4'b0000,0);
    vt[8]  = mk(0,1,5'h0A,16'hAAAA,4'b1100,1,1, 1,1,16'hAAAA,16'h0000,0,4'b1100,0);
    vt[9]  = mk(0,1,5'h0F,16'h1111,4'b0000,1,1, 1,0,16'h0000,16'h0000,0,4'b1100,0);
    vt[10] = mk(0,0,5'h0F,16'h0000,4'b0000,1,1, 1,0,16'h0000,16'h0000,0,4'b1100,1);
    vt[11] = mk(0,0,5'h00,16'h0000,4'b0000,0,1, 1,0,16'h0000,16'h0000,0,4'b1100,0);
    vt[12] = mk(0,1,5'h0F,16'h2222,4'b0000,1,1, 1,0,16'h0000,16'h0000,0,4'b1100,0);
    vt[13] = mk(0,1,5'h0A,16'h0042,4'b0000,1,1, 1,1,16'h0042,16'h0000,0,4'b0000,1);
    vt[14] = mk(0,1,5'h0A,16'h8000,4'b1001,1,1, 1,1,16'h8000,16'h0000,0,4'b1001,0);
    vt[15] = mk(0,1,5'h0B,16'h0BEE,4'b0110,0,1, 1,1,16'h0BEE,16'h0000,0,4'b1001,0);
    vt[16] = mk(0,1,5'h10,16'h00AA,4'b0000,1,1, 1,0,16'h0000,16'h0000,0,4'b1001,0);
    vt[17] = mk(0,1,5'h10,16'h00BB,4'b0100,0,1, 1,1,16'h00AA,16'h00BB,1,4'b1001,0);
    vt[18] = mk(0,0,5'h00,16'h0000,4'b0000,0,1, 1,0,16'h0000,16'h0000,0,4'b1001,0);
    vt[19] = mk(0,1,5'h11,16'h0001,4'b0000,1,1, 1,0,16'h0000,16'h0000,0,4'b1001,0);
    vt[20] = mk(0,1,5'h09,16'h3333,4'b0000,1,1, 1,0,16'h0000,16'h0000,0,4'b1001,1);
    vt[21] = mk(0,1,5'h09,16'h4444,4'b0010,1,1, 1,1,16'h3333,16'h4444,1,4'b0010,0);
    vt[22] = mk(0,0,5'h00,16'h0000,4'b0000,0,1, 1,0,16'h0000,16'h0000,0,4'b0010,0);

    drive(1,0,5'h00,16'h0000,4'b0000,0,1);
    #1;
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].rst, vt[i].v, vt[i].code, vt[i].res, vt[i].fl_in, vt[i].fwe, vt[i].ordy);
      #1;
      if (!vt[i].rst) chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'(vt[i].ir));
      tick();
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'(vt[i].ov));
      chk($sformatf("v%0d flags_out", i), 32'(bus.flags_out), 32'(vt[i].fl));
      chk($sformatf("v%0d carry_to_alu", i), 32'(bus.carry_to_alu), 32'(vt[i].fl[2]));
      chk($sformatf("v%0d seq_error", i), 32'(bus.seq_error), 32'(vt[i].se));
      if (vt[i].ov || vt[i].rst) begin
        chk($sformatf("v%0d result_lo", i), 32'(bus.result_lo), 32'(vt[i].lo));
        chk($sformatf("v%0d result_hi", i), 32'(bus.result_hi), 32'(vt[i].hi));
        chk($sformatf("v%0d wide", i), 32'(bus.wide), 32'(vt[i].w));
      end
    end

    // Reset while a pair is half-collected.
    drive(0,1,5'h0E,16'h7777,4'b0000,1,1);
    tick();
    chk("rstHI pre out_valid", 32'(bus.out_valid), 32'd0);
    drive(1,1,5'h0E,16'h8888,4'b0100,1,1);
    tick();
    drive(0,0,5'h00,16'h0000,4'b0000,0,0);
    #1;
    chk("rstHI out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstHI flags_out", 32'(bus.flags_out), 32'd0);
    chk("rstHI seq_error", 32'(bus.seq_error), 32'd0);
    chk("rstHI in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("rstHI no late seq_error", 32'(bus.seq_error), 32'd0);

    // Reset while a result is stalled in FULL.
    drive(0,1,5'h0A,16'h0055,4'b0100,1,0);
    tick();
    chk("rstFULL pre out_valid", 32'(bus.out_valid), 32'd1);
    chk("rstFULL pre result_lo", 32'(bus.result_lo), 32'h0055);
    chk("rstFULL pre flags_out", 32'(bus.flags_out), 32'b0100);
    drive(1,0,5'h00,16'h0000,4'b0000,0,0);
    tick();
    drive(0,0,5'h00,16'h0000,4'b0000,0,0);
    #1;
    chk("rstFULL out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstFULL result_lo", 32'(bus.result_lo), 32'd0);
    chk("rstFULL flags_out", 32'(bus.flags_out), 32'd0);
    chk("rstFULL carry_to_alu", 32'(bus.carry_to_alu), 32'd0);
    chk("rstFULL seq_error", 32'(bus.seq_error), 32'd0);
    chk("rstFULL in_ready", 32'(bus.in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
